// File: rtl/ntsc_line_timing_if.sv
// rtl/ntsc_line_timing_if.sv - pixel stream interface from frame-buffer reader to line timing
interface ntsc_line_timing_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s00_axis_tvalid;
    logic                  s00_axis_tready;
    logic [DATA_WIDTH-1:0] s00_axis_tdata;
    logic                  s00_axis_tlast;

    modport master (
        output s00_axis_tvalid,
        output s00_axis_tdata,
        output s00_axis_tlast,
        input  s00_axis_tready
    );

    modport slave (
        input  s00_axis_tvalid,
        input  s00_axis_tdata,
        input  s00_axis_tlast,
        output s00_axis_tready
    );
endinterface

// File: rtl/ntsc_line_timing.sv
// rtl/ntsc_line_timing.sv - NTSC raster timing and composite sample generator
module ntsc_line_timing #(
    parameter int H_ACTIVE    = 720,
    parameter int H_SYNC      = 64,
    parameter int H_BACK      = 58,
    parameter int H_FRONT     = 16,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 6,
    parameter int V_BACK      = 30,
    parameter int V_FRONT     = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_LEVEL  = 0,
    parameter int BLANK_LEVEL = 72,
    parameter int WHITE_SPAN  = 183
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_areset,
    ntsc_line_timing_if.slave    s_axis,
    input  logic                 err_clr,
    output logic [7:0]           sample_out,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 frame_start,
    output logic                 underflow,
    output logic                 desync
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {RUN, RESYNC, WAIT_FRAME} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [7:0]      sample_q, sample_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d;
    logic            active_q, active_d, frame_start_q, frame_start_d;
    logic            underflow_q, underflow_d, desync_q, desync_d;

    logic            in_active, is_final, at_origin, tready, fire, fire_last;
    logic            uf_set, ds_set;
    logic [15:0]     luma_prod;
    logic            unused_bits;

    assign in_active = (v_cnt_q >= VW'(V_START)) && (v_cnt_q < VW'(V_START + V_ACTIVE)) &&
                       (h_cnt_q >= HW'(H_START)) && (h_cnt_q < HW'(H_START + H_ACTIVE));
    assign is_final  = (v_cnt_q == VW'(V_START + V_ACTIVE - 1)) &&
                       (h_cnt_q == HW'(H_START + H_ACTIVE - 1));
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Gated by reset so that no beat is taken on the reset edge
    assign tready    = !s00_axis_areset &&
                       (((state_q == RUN) && in_active) || (state_q == RESYNC));
    assign s_axis.s00_axis_tready = tready;
    assign fire      = s_axis.s00_axis_tvalid && tready;
    assign fire_last = fire && s_axis.s00_axis_tlast;

    assign luma_prod   = {8'd0, s_axis.s00_axis_tdata[7:0]} * 16'(WHITE_SPAN);
    assign unused_bits = ^{s_axis.s00_axis_tdata[DATA_WIDTH-1:8], luma_prod[7:0]};

    always_comb begin
        h_cnt_d  = (h_cnt_q == HW'(H_TOTAL - 1)) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d  = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end

        state_d = state_q;
        uf_set  = 1'b0;
        ds_set  = 1'b0;
        case (state_q)
            RUN: begin
                uf_set = in_active && !s_axis.s00_axis_tvalid;
                if (fire_last && !is_final) begin
                    ds_set  = 1'b1;
                    state_d = WAIT_FRAME;
                end else if (is_final && !fire_last) begin
                    ds_set  = 1'b1;
                    state_d = RESYNC;
                end
            end
            RESYNC: begin
                if (fire_last) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (at_origin) state_d = RUN;
            end
            default: state_d = WAIT_FRAME;
        endcase

        // Vsync lines carry a blank serration across the last H_SYNC samples
        if (v_cnt_q < VW'(V_SYNC)) begin
            sample_d = (h_cnt_q >= HW'(H_TOTAL - H_SYNC)) ? 8'(BLANK_LEVEL) : 8'(SYNC_LEVEL);
        end else if (h_cnt_q < HW'(H_SYNC)) begin
            sample_d = 8'(SYNC_LEVEL);
        end else if ((state_q == RUN) && fire) begin
            sample_d = 8'(BLANK_LEVEL) + luma_prod[15:8];
        end else begin
            sample_d = 8'(BLANK_LEVEL);
        end

        hsync_d       = h_cnt_q < HW'(H_SYNC);
        vsync_d       = v_cnt_q < VW'(V_SYNC);
        active_d      = in_active;
        frame_start_d = at_origin;
        underflow_d   = uf_set || (underflow_q && !err_clr);
        desync_d      = ds_set || (desync_q && !err_clr);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q       <= WAIT_FRAME;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            sample_q      <= 8'(SYNC_LEVEL);
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            desync_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            sample_q      <= sample_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            desync_q      <= desync_d;
        end
    end

    assign sample_out  = sample_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign desync      = desync_q;
endmodule

// File: tb/tb_ntsc_line_timing.sv
// tb/tb_ntsc_line_timing.sv - scoreboard bench for ntsc_line_timing on a reduced raster
module tb_ntsc_line_timing;
    localparam int HS = 4, HB = 3, HA = 8, HF = 3;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FR = HT * VT;
    localparam int HSTART = HS + HB;
    localparam int VSTART = VS + VB;
    localparam int NPIX = HA * VA;
    localparam int M_RUN = 0, M_RESYNC = 1, M_WAIT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] sample_out;
    logic       hsync, vsync, active, frame_start, underflow, desync;

    always #5 clk = ~clk;

    ntsc_line_timing_if #(.DATA_WIDTH(32)) axis ();

    ntsc_line_timing #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_FRONT(HF),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
        .DATA_WIDTH(32), .SYNC_LEVEL(0), .BLANK_LEVEL(72), .WHITE_SPAN(183)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s_axis         (axis.slave),
        .err_clr        (err_clr),
        .sample_out     (sample_out),
        .hsync          (hsync),
        .vsync          (vsync),
        .active         (active),
        .frame_start    (frame_start),
        .underflow      (underflow),
        .desync         (desync)
    );

    typedef struct packed {
        logic [7:0] s;
        logic hs, vs, ac, fs, uf, ds;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;
    int   pos, st, pix, bad_last = -1;
    bit   m_uf, m_ds;
    int   cnt_rdy, cnt_hs, cnt_vs, cnt_act, cnt_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int lum(input int y);
        case (y)
            0:       return 72;
            128:     return 163;
            255:     return 254;
            default: return 72 + ((y * 183) / 256);
        endcase
    endfunction

    function automatic int ypat(input int p);
        case (p % 4)
            0:       return 0;
            1:       return 128;
            2:       return 255;
            default: return (p * 37) % 256;
        endcase
    endfunction

    task automatic clear_counts();
        cnt_rdy = 0; cnt_hs = 0; cnt_vs = 0; cnt_act = 0; cnt_fs = 0;
    endtask

    task automatic cyc(input bit v, input bit clr);
        exp_t e, o;
        int   h, vv, y;
        bit   act, fin, rdy, fire, last, ufs, dss;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            o = {sample_out, hsync, vsync, active, frame_start, underflow, desync};
            chk("outputs", 32'(o), 32'(e));
        end
        cnt_hs  += int'(hsync);
        cnt_vs  += int'(vsync);
        cnt_act += int'(active);
        cnt_fs  += int'(frame_start);

        h    = pos % HT;
        vv   = pos / HT;
        act  = (vv >= VSTART) && (vv < VSTART + VA) && (h >= HSTART) && (h < HSTART + HA);
        fin  = (vv == VSTART + VA - 1) && (h == HSTART + HA - 1);
        y    = ypat(pix);
        last = (pix == NPIX - 1) || (pix == bad_last);

        axis.s00_axis_tvalid = v;
        axis.s00_axis_tdata  = {24'($urandom), 8'(y)};
        axis.s00_axis_tlast  = last;
        err_clr              = clr;
        #1;
        rdy = ((st == M_RUN) && act) || (st == M_RESYNC);
        chk("tready", 32'(axis.s00_axis_tready), 32'(rdy));
        cnt_rdy += int'(axis.s00_axis_tready);
        fire = v && rdy;

        if (vv < VS)                 e.s = (h >= HT - HS) ? 8'd72 : 8'd0;
        else if (h < HS)             e.s = 8'd0;
        else if (st == M_RUN && fire) e.s = 8'(lum(y));
        else                         e.s = 8'd72;
        e.hs = (h < HS);
        e.vs = (vv < VS);
        e.ac = act;
        e.fs = (pos == 0);

        ufs = 0;
        dss = 0;
        case (st)
            M_RUN: begin
                ufs = act && !v;
                if (fire && last && !fin) begin
                    dss = 1; st = M_WAIT;
                end else if (fin && !(fire && last)) begin
                    dss = 1; st = M_RESYNC;
                end
            end
            M_RESYNC: if (fire && last) st = M_WAIT;
            default:  if (pos == 0) st = M_RUN;
        endcase
        m_uf = ufs || (m_uf && !clr);
        m_ds = dss || (m_ds && !clr);
        e.uf = m_uf;
        e.ds = m_ds;
        sb.push_back(e);

        if (fire) pix = last ? 0 : pix + 1;
        pos = (pos + 1) % FR;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        axis.s00_axis_tvalid = 1'b1;
        axis.s00_axis_tdata  = '0;
        axis.s00_axis_tlast  = 1'b0;
        err_clr              = 1'b0;
        #1;
        chk("tready_during_reset", 32'(axis.s00_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        rst                  = 1'b0;
        axis.s00_axis_tvalid = 1'b0;
        #1;
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_desync", 32'(desync), 32'd0);
        chk("rst_tready", 32'(axis.s00_axis_tready), 32'd0);
        pos = 0; st = M_WAIT; pix = 0; m_uf = 0; m_ds = 0;
        sb.delete();
    endtask

    initial begin
        // Reset, then frame 1 starting straight from WAIT_FRAME at the origin
        do_reset();
        clear_counts();
        cyc(1, 0);
        chk("first_frame_start", 32'(frame_start), 32'd1);
        chk("first_sample_sync", 32'(sample_out), 32'd0);
        chk("first_hsync", 32'(hsync), 32'd1);
        chk("first_vsync", 32'(vsync), 32'd1);
        for (int i = 1; i < FR; i++) cyc(1, 0);
        chk("f1_tready_count", 32'(cnt_rdy), 32'(NPIX));

        // Frame 2: clean frame, raster shape counts
        clear_counts();
        for (int i = 0; i < FR; i++) cyc(1, 0);
        chk("f2_tready_count", 32'(cnt_rdy), 32'(NPIX));
        chk("f2_active_count", 32'(cnt_act), 32'(HA * VA));
        chk("f2_hsync_count", 32'(cnt_hs), 32'(HS * VT));
        chk("f2_vsync_count", 32'(cnt_vs), 32'(HT * VS));
        chk("f2_frame_start_count", 32'(cnt_fs), 32'd1);
        chk("f2_underflow", 32'(underflow), 32'd0);
        chk("f2_desync", 32'(desync), 32'd0);

        // Frame 3: tvalid dropped 5 cycles on an active line, tlast arrives late
        for (int i = 0; i < FR; i++) begin
            cyc(!((i >= (VSTART + 1) * HT + HSTART + 2) && (i < (VSTART + 1) * HT + HSTART + 7)), 0);
        end
        chk("f3_underflow", 32'(underflow), 32'd1);
        chk("f3_desync", 32'(desync), 32'd1);

        // Frame 4: early tlast on pixel 10
        bad_last = 10;
        clear_counts();
        for (int i = 0; i < FR; i++) cyc(1, 0);
        bad_last = -1;
        chk("f4_tready_count", 32'(cnt_rdy), 32'd11);
        chk("f4_desync", 32'(desync), 32'd1);

        // Frame 5: clear flags, then err_clr coinciding with an underflow event
        for (int i = 0; i < FR; i++) begin
            if (i == 50) begin
                chk("f5_cleared_underflow", 32'(underflow), 32'd0);
                chk("f5_cleared_desync", 32'(desync), 32'd0);
            end
            if (i == VSTART * HT + HSTART) cyc(0, 1);
            else cyc(1, i == 0);
            if (i == VSTART * HT + HSTART) chk("f5_set_wins", 32'(underflow), 32'd1);
        end

        // Frame 6: clear and run clean
        clear_counts();
        for (int i = 0; i < FR; i++) cyc(1, i == 0);
        chk("f6_tready_count", 32'(cnt_rdy), 32'(NPIX));
        chk("f6_underflow", 32'(underflow), 32'd0);
        chk("f6_desync", 32'(desync), 32'd0);

        // Frame 7: set underflow, then reset mid-stream on line 6
        for (int i = 0; i < 6 * HT + 10; i++) cyc(i != VSTART * HT + HSTART + 1, 0);
        chk("f7_pre_reset_underflow", 32'(underflow), 32'd1);
        do_reset();
        cyc(1, 0);
        chk("post_reset_frame_start", 32'(frame_start), 32'd1);
        clear_counts();
        for (int i = 1; i < FR; i++) cyc(1, 0);
        chk("post_reset_tready_count", 32'(cnt_rdy), 32'(NPIX));
        chk("post_reset_underflow", 32'(underflow), 32'd0);
        chk("post_reset_desync", 32'(desync), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
